// File: rtl/sobel_window_stream.sv
// Builds 3x3 Sobel windows from a 3-row x WIN_W tile that is filled from GRP-pixel beats.
// Rows roll forward one per sweep; the sweep direction optionally alternates between rows.
module sobel_window_stream #(
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned WIN_W      = 8,
    parameter int unsigned GRP        = 4,
    parameter int unsigned SERPENTINE = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [GRP*PIX_W-1:0]       in_pixels,
    input  logic                       in_last,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*PIX_W-1:0]         win_data,
    output logic [$clog2(WIN_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int unsigned N_GRP  = WIN_W / GRP;
    localparam int unsigned GRP_CW = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int unsigned COL_W  = $clog2(WIN_W);

    localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIN_W - 2);
    localparam logic [GRP_CW-1:0] GRP_LAST  = GRP_CW'(N_GRP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL3,
        S_SWEEP,
        S_ADVANCE,
        S_FILL1,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [GRP_CW-1:0]     grp_q, grp_d;
    logic [1:0]            row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic                  dir_q, dir_d;
    logic                  last_q, last_d;
    logic                  in_ready_q, in_ready_d;
    logic                  win_valid_q, win_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [9*PIX_W-1:0]    win_data_q, win_data_d;
    logic [PIX_W-1:0]      tile_q [3][WIN_W];
    logic [PIX_W-1:0]      tile_d [3][WIN_W];

    logic                  in_fire;
    logic                  win_fire;
    logic [COL_W-1:0]      base;
    logic [COL_W-1:0]      idx;

    assign in_fire  = in_ready_q && in_valid;
    assign win_fire = win_valid_q && win_ready;

    // Next-state, tile update and output flags
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        row_d   = row_q;
        col_d   = col_q;
        dir_d   = dir_q;
        last_d  = last_q;
        tile_d  = tile_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL3;
                    grp_d   = '0;
                    row_d   = 2'd2;
                    last_d  = 1'b0;
                end
            end
            S_FILL3, S_FILL1: begin
                if (in_fire) begin
                    for (int g = 0; g < int'(GRP); g++) begin
                        tile_d[row_q][COL_W'(int'(grp_q) * int'(GRP) + g)] =
                            in_pixels[g*PIX_W +: PIX_W];
                    end
                    if (in_last) last_d = 1'b1;
                    if (grp_q == GRP_LAST) begin
                        grp_d = '0;
                        if (row_q == 2'd0) begin
                            state_d = S_SWEEP;
                            col_d   = dir_q ? COL_LAST : COL_FIRST;
                        end else begin
                            row_d = row_q - 2'd1;
                        end
                    end else begin
                        grp_d = grp_q + GRP_CW'(1);
                    end
                end
            end
            S_SWEEP: begin
                if (win_fire) begin
                    if (col_q == (dir_q ? COL_FIRST : COL_LAST)) begin
                        state_d = last_q ? S_DONE : S_ADVANCE;
                    end else begin
                        col_d = dir_q ? (col_q - COL_W'(1)) : (col_q + COL_W'(1));
                    end
                end
            end
            S_ADVANCE: begin
                tile_d[2] = tile_q[1];
                tile_d[1] = tile_q[0];
                if (SERPENTINE != 0) dir_d = ~dir_q;
                state_d = S_FILL1;
                grp_d   = '0;
                row_d   = 2'd0;
                last_d  = 1'b0;
            end
            S_DONE: begin
                dir_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d   = (state_d == S_FILL3) || (state_d == S_FILL1);
        win_valid_d  = (state_d == S_SWEEP);
        frame_done_d = (state_d == S_DONE);
    end

    // Window taken from next-cycle tile/column so it is aligned with win_valid and frozen on stall
    always_comb begin
        win_data_d = '0;
        base       = (col_d == '0) ? '0 : (col_d - COL_W'(1));
        idx        = base;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                idx = base + COL_W'(j);
                win_data_d[(3*r + j)*PIX_W +: PIX_W] = tile_d[r][idx];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            grp_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            dir_q        <= 1'b0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < int'(WIN_W); c++) begin
                    tile_q[r][c] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            grp_q        <= grp_d;
            row_q        <= row_d;
            col_q        <= col_d;
            dir_q        <= dir_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_data_q   <= win_data_d;
            tile_q       <= tile_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_col    = col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_stream.sv
// Directed bench for sobel_window_stream: serpentine and non-serpentine instances share stimulus;
// window contents come from the pixel formula value = fill_row*10 + column.
module tb_sobel_window_stream;

    localparam int PIX_W = 8;
    localparam int WIN_W = 8;
    localparam int GRP   = 4;
    localparam int NCOL  = WIN_W - 2;
    localparam int NBEAT = WIN_W / GRP;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 start;
    logic                 in_valid;
    logic [GRP*PIX_W-1:0] in_pixels;
    logic                 in_last;
    logic                 win_ready;

    logic                 in_ready,   in_ready_np;
    logic                 win_valid,  win_valid_np;
    logic [9*PIX_W-1:0]   win_data,   win_data_np;
    logic [2:0]           win_col,    win_col_np;
    logic                 frame_done, frame_done_np;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sobel_window_stream #(.PIX_W(PIX_W), .WIN_W(WIN_W), .GRP(GRP), .SERPENTINE(1)) u_dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels), .in_last(in_last),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_col(win_col), .frame_done(frame_done)
    );

    sobel_window_stream #(.PIX_W(PIX_W), .WIN_W(WIN_W), .GRP(GRP), .SERPENTINE(0)) u_dut_np (
        .clk(clk), .n_rst(n_rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready_np), .in_pixels(in_pixels), .in_last(in_last),
        .win_valid(win_valid_np), .win_ready(win_ready), .win_data(win_data_np),
        .win_col(win_col_np), .frame_done(frame_done_np)
    );

    typedef struct {
        int rows;
        bit gaps;
        int stall_sweep;
        int exp_windows;
    } vec_t;

    task automatic check(input string nm, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int row, input int col);
        return 8'(row * 10 + col);
    endfunction

    function automatic logic [71:0] exp_win(input int s, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
                w[(3*r + j)*8 +: 8] = pix(s + 2 - r, c - 1 + j);
        return w;
    endfunction

    function automatic int exp_col(input int s, input int w, input bit serp);
        if (serp && (s % 2 == 1)) return NCOL - w;
        return w + 1;
    endfunction

    // Present one beat at a negedge and return at the negedge after it is accepted
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        in_pixels = d;
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 72'(in_ready), 72'(1));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume_sweep(input int s, input bit stall, output int nwin);
        int n;
        int cnt;
        logic [2:0]  held_col;
        logic [71:0] held_data;
        cnt = 0;
        for (int w = 0; w < NCOL; w++) begin
            n = 0;
            while (!win_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!win_valid) begin
                check("win_valid_timeout", 72'(win_valid), 72'(1));
                nwin = cnt;
                return;
            end
            check("win_col",     72'(win_col),    72'(exp_col(s, w, 1'b1)));
            check("win_data",    win_data,        exp_win(s, exp_col(s, w, 1'b1)));
            check("np_win_col",  72'(win_col_np), 72'(exp_col(s, w, 1'b0)));
            check("np_win_data", win_data_np,     exp_win(s, exp_col(s, w, 1'b0)));
            cnt++;
            if (stall && w == 2) begin
                win_ready = 1'b0;
                start     = 1'b1;
                held_col  = win_col;
                held_data = win_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    start = 1'b0;
                    check("stall_col",   72'(win_col),   72'(held_col));
                    check("stall_data",  win_data,       held_data);
                    check("stall_valid", 72'(win_valid), 72'(1));
                end
                win_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("sweep_end_valid", 72'(win_valid), 72'(0));
        check("sweep_end_ready", 72'(in_ready),  72'(0));
        nwin = cnt;
    endtask

    task automatic run_frame(input vec_t v, output int total);
        logic [31:0] d;
        int k;
        total = 0;
        // start with a simultaneous junk beat; it must not be taken
        @(negedge clk);
        start     = 1'b1;
        in_valid  = 1'b1;
        in_pixels = 32'hFFFF_FFFF;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < v.rows; i++) begin
            for (int b = 0; b < NBEAT; b++) begin
                for (int g = 0; g < GRP; g++) d[g*8 +: 8] = pix(i, b*GRP + g);
                send_beat(d, logic'(i == v.rows - 1));
                if (i >= 2 && b == NBEAT - 1) begin
                    check("fill_latency", 72'(win_valid), 72'(1));
                end else if (v.gaps) begin
                    @(negedge clk);
                end
            end
            if (i >= 2) begin
                consume_sweep(i - 2, bit'(v.stall_sweep == i - 2), k);
                total += k;
            end
        end
        check("frame_done",    72'(frame_done),    72'(1));
        check("np_frame_done", 72'(frame_done_np), 72'(1));
        @(negedge clk);
        check("frame_done_pulse", 72'(frame_done), 72'(0));
    endtask

    vec_t vecs[4];
    int   nwin;

    initial begin
        vecs[0] = '{rows: 3, gaps: 1'b0, stall_sweep: -1, exp_windows: 6};
        vecs[1] = '{rows: 5, gaps: 1'b0, stall_sweep: -1, exp_windows: 18};
        vecs[2] = '{rows: 4, gaps: 1'b1, stall_sweep: 1,  exp_windows: 12};
        vecs[3] = '{rows: 3, gaps: 1'b1, stall_sweep: 0,  exp_windows: 6};

        n_rst     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_pixels = '0;
        in_last   = 1'b0;
        win_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   72'(in_ready),   72'(0));
        check("rst_win_valid",  72'(win_valid),  72'(0));
        check("rst_win_data",   win_data,        72'(0));
        check("rst_win_col",    72'(win_col),    72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 72'(in_ready), 72'(0));

        for (int t = 0; t < 4; t++) begin
            run_frame(vecs[t], nwin);
            check($sformatf("vec%0d_windows", t), 72'(nwin), 72'(vecs[t].exp_windows));
        end

        // Reset mid-sweep, then a clean refill
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 3 * NBEAT; b++) send_beat(32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 72'(win_valid), 72'(1));
        n_rst = 1'b0;
        #1;
        check("midrst_in_ready",   72'(in_ready),   72'(0));
        check("midrst_win_valid",  72'(win_valid),  72'(0));
        check("midrst_win_data",   win_data,        72'(0));
        check("midrst_win_col",    72'(win_col),    72'(0));
        check("midrst_frame_done", 72'(frame_done), 72'(0));
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 72'(in_ready), 72'(0));
        run_frame(vecs[0], nwin);
        check("post_rst_windows", 72'(nwin), 72'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
